// File: rtl/zeroriscy_vector_pkg.sv
// Shared types and constants for the vector sequencer and its register file.
// The ALU opcode values match the encoding the vector ALU decodes.
package zeroriscy_vector_pkg;

    localparam int VLANES        = 4;
    localparam int VEC_NUM_VREGS = 8;
    localparam int VEC_MAX_VL    = 16;
    localparam int VREG_W        = $clog2(VEC_NUM_VREGS);
    localparam int VL_W          = $clog2(VEC_MAX_VL) + 1;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_SRL = 4'd3;
    localparam logic [3:0] ALU_SRA = 4'd4;

    typedef logic [VLANES-1:0][31:0] vlane_t;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_EXEC, SEQ_DONE} seq_state_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [VREG_W-1:0] vd;
        logic [VREG_W-1:0] vs1;
        logic [VREG_W-1:0] vs2;
        logic [VL_W-1:0]   vl;
    } vec_cmd_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLL) ||
               (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/zeroriscy_vector_regfile.sv
// Vector register file organised as [vreg][beat] lane-vectors: two lane-vector
// read ports, one masked lane-vector write port, one host scalar write/read port.
module zeroriscy_vector_regfile
    import zeroriscy_vector_pkg::*;
#(
    parameter int NUM_VREGS = VEC_NUM_VREGS,
    parameter int MAX_VL    = VEC_MAX_VL,
    localparam int VW       = $clog2(NUM_VREGS),
    localparam int IW       = $clog2(MAX_VL),
    localparam int BEATS    = MAX_VL / VLANES,
    localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VW-1:0]     ra_vreg,
    input  logic [BW-1:0]     ra_beat,
    output vlane_t            ra_data,
    input  logic [VW-1:0]     rb_vreg,
    input  logic [BW-1:0]     rb_beat,
    output vlane_t            rb_data,
    input  logic [VLANES-1:0] w_mask,
    input  logic [VW-1:0]     w_vreg,
    input  logic [BW-1:0]     w_beat,
    input  vlane_t            w_data,
    input  logic              h_we,
    input  logic [VW-1:0]     h_waddr,
    input  logic [IW-1:0]     h_widx,
    input  logic [31:0]       h_wdata,
    input  logic [VW-1:0]     h_raddr,
    input  logic [IW-1:0]     h_ridx,
    output logic [31:0]       h_rdata
);

    vlane_t        mem_q [NUM_VREGS][BEATS];
    vlane_t        mem_d [NUM_VREGS][BEATS];
    logic [31:0]   h_rdata_q;
    logic [31:0]   h_rdata_d;
    logic [BW-1:0] h_wbeat;
    logic [BW-1:0] h_rbeat;
    logic [1:0]    h_wlane;
    logic [1:0]    h_rlane;

    assign h_wbeat = BW'(h_widx >> 2);
    assign h_wlane = h_widx[1:0];
    assign h_rbeat = BW'(h_ridx >> 2);
    assign h_rlane = h_ridx[1:0];

    assign ra_data = mem_q[ra_vreg][ra_beat];
    assign rb_data = mem_q[rb_vreg][rb_beat];
    assign h_rdata = h_rdata_q;

    always_comb begin
        mem_d = mem_q;
        if (h_we) begin
            mem_d[h_waddr][h_wbeat][h_wlane] = h_wdata;
        end
        for (int l = 0; l < VLANES; l++) begin
            if (w_mask[l]) begin
                mem_d[w_vreg][w_beat][l] = w_data[l];
            end
        end
        // Read-old: sample the pre-edge contents even when the same element is written.
        h_rdata_d = mem_q[h_raddr][h_rbeat][h_rlane];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            h_rdata_q <= '0;
        end else begin
            mem_q     <= mem_d;
            h_rdata_q <= h_rdata_d;
        end
    end

endmodule

// File: rtl/zeroriscy_vector_seq.sv
// Vector sequencer: latches one command, strip-mines it into 4-lane beats that
// drive the external combinational ALU, and writes each beat's result back to vd.
module zeroriscy_vector_seq
    import zeroriscy_vector_pkg::*;
#(
    parameter int NUM_VREGS = VEC_NUM_VREGS,
    parameter int MAX_VL    = VEC_MAX_VL,
    localparam int VW       = $clog2(NUM_VREGS),
    localparam int IW       = $clog2(MAX_VL),
    localparam int LW       = IW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [VW-1:0] cmd_vd,
    input  logic [VW-1:0] cmd_vs1,
    input  logic [VW-1:0] cmd_vs2,
    input  logic [LW-1:0] cmd_vl,
    output logic          done,
    output logic          busy,
    output vlane_t        alu_argA,
    output vlane_t        alu_argB,
    output logic [3:0]    alu_opcode,
    input  vlane_t        alu_res,
    input  logic          reg_we,
    input  logic [VW-1:0] reg_waddr,
    input  logic [IW-1:0] reg_widx,
    input  logic [31:0]   reg_wdata,
    input  logic [VW-1:0] reg_raddr,
    input  logic [IW-1:0] reg_ridx,
    output logic [31:0]   reg_rdata
);

    localparam int BEATS = MAX_VL / VLANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    seq_state_t        state_q, state_d;
    vec_cmd_t          cmd_q, cmd_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [BW-1:0]     last_q, last_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [LW-1:0]     vl_eff;
    logic [LW-1:0]     nbeats;
    logic              exec;
    logic              accept;
    logic [VLANES-1:0] wmask;
    vlane_t            rd_a;
    vlane_t            rd_b;

    assign exec   = (state_q == SEQ_EXEC);
    assign accept = cmd_valid && ready_q;
    assign vl_eff = (cmd_vl > LW'(MAX_VL)) ? LW'(MAX_VL) : cmd_vl;
    assign nbeats = (vl_eff + LW'(3)) >> 2;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        beat_d  = beat_q;
        last_d  = last_q;
        case (state_q)
            SEQ_IDLE: begin
                if (accept) begin
                    cmd_d.op  = cmd_op;
                    cmd_d.vd  = cmd_vd;
                    cmd_d.vs1 = cmd_vs1;
                    cmd_d.vs2 = cmd_vs2;
                    cmd_d.vl  = vl_eff;
                    beat_d    = '0;
                    last_d    = BW'(nbeats - LW'(1));
                    state_d   = (vl_eff == '0) ? SEQ_DONE : SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (beat_q == last_q) begin
                    state_d = SEQ_DONE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            SEQ_DONE: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
        done_d  = (state_d == SEQ_DONE);
        ready_d = (state_d == SEQ_IDLE);
        busy_d  = (state_d != SEQ_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            cmd_q   <= '0;
            beat_q  <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Lanes past vl, and every lane of an unknown opcode, keep their old contents.
    for (genvar gi = 0; gi < VLANES; gi++) begin : g_lane
        logic [LW-1:0] elem_idx;
        assign elem_idx     = LW'({beat_q, 2'(gi)});
        assign wmask[gi]    = exec && is_alu_op(cmd_q.op) && (elem_idx < cmd_q.vl);
        assign alu_argA[gi] = exec ? rd_a[gi] : 32'd0;
        assign alu_argB[gi] = exec ? rd_b[gi] : 32'd0;
    end

    zeroriscy_vector_regfile #(
        .NUM_VREGS (NUM_VREGS),
        .MAX_VL    (MAX_VL)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_vreg (cmd_q.vs1),
        .ra_beat (beat_q),
        .ra_data (rd_a),
        .rb_vreg (cmd_q.vs2),
        .rb_beat (beat_q),
        .rb_data (rd_b),
        .w_mask  (wmask),
        .w_vreg  (cmd_q.vd),
        .w_beat  (beat_q),
        .w_data  (alu_res),
        .h_we    (reg_we && (state_q == SEQ_IDLE)),
        .h_waddr (reg_waddr),
        .h_widx  (reg_widx),
        .h_wdata (reg_wdata),
        .h_raddr (reg_raddr),
        .h_ridx  (reg_ridx),
        .h_rdata (reg_rdata)
    );

    assign cmd_ready  = ready_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign alu_opcode = cmd_q.op;

endmodule

// File: tb/tb_zeroriscy_vector_seq.sv
// Scoreboard bench: host reads push expected data, a monitor checks reg_rdata
// one cycle later; the bench models the 4-lane ALU itself.
module tb_zeroriscy_vector_seq;
    import zeroriscy_vector_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [2:0]  cmd_vd = '0, cmd_vs1 = '0, cmd_vs2 = '0;
    logic [4:0]  cmd_vl = '0;
    logic        done, busy;
    vlane_t      alu_argA, alu_argB, alu_res;
    logic [3:0]  alu_opcode;
    logic        reg_we = 1'b0;
    logic [2:0]  reg_waddr = '0, reg_raddr = '0;
    logic [3:0]  reg_widx = '0, reg_ridx = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;

    int tests = 0;
    int fails = 0;
    logic        rd_req = 1'b0;
    logic        rd_valid = 1'b0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    zeroriscy_vector_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vl(cmd_vl),
        .done(done), .busy(busy),
        .alu_argA(alu_argA), .alu_argB(alu_argB), .alu_opcode(alu_opcode), .alu_res(alu_res),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_widx(reg_widx), .reg_wdata(reg_wdata),
        .reg_raddr(reg_raddr), .reg_ridx(reg_ridx), .reg_rdata(reg_rdata)
    );

    // Reference model of the external combinational ALU.
    always_comb begin
        for (int l = 0; l < VLANES; l++) begin
            case (alu_opcode)
                ALU_ADD: alu_res[l] = alu_argA[l] + alu_argB[l];
                ALU_SUB: alu_res[l] = alu_argA[l] - alu_argB[l];
                ALU_SLL: alu_res[l] = alu_argA[l] << alu_argB[l][4:0];
                ALU_SRL: alu_res[l] = alu_argA[l] >> alu_argB[l][4:0];
                ALU_SRA: alu_res[l] = $unsigned($signed(alu_argA[l]) >>> alu_argB[l][4:0]);
                default: alu_res[l] = 32'd0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", name, act);
        end
    endtask

    always @(posedge clk) rd_valid <= rd_req && !rst;

    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", reg_rdata, 32'hFFFF_FFFF);
            end else begin
                check(name_q.pop_front(), reg_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
        reg_we = 1'b0; rd_req = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic hw(input int v, input int i, input logic [31:0] d);
        step();
        reg_we = 1'b1; reg_waddr = 3'(v); reg_widx = 4'(i); reg_wdata = d;
    endtask

    task automatic rd(input int v, input int i, input logic [31:0] e);
        step();
        rd_req = 1'b1; reg_raddr = 3'(v); reg_ridx = 4'(i);
        exp_q.push_back(e);
        name_q.push_back($sformatf("v%0d[%0d]", v, i));
    endtask

    task automatic drain();
        step();
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
        if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // mode 1: host write v0[0] during the whole command (must be dropped)
    // mode 2: host write v2[0]=0x10 in the accept cycle (must land before beat 0)
    task automatic run_cmd(input logic [3:0] op, input int vd, input int vs1, input int vs2,
                           input int vl, input int exp_cyc, input int mode, input string name);
        int cyc;
        logic seen;
        step();
        cmd_valid = 1'b1; cmd_op = op; cmd_vd = 3'(vd); cmd_vs1 = 3'(vs1);
        cmd_vs2 = 3'(vs2); cmd_vl = 5'(vl);
        if (mode == 2) begin
            reg_we = 1'b1; reg_waddr = 3'd2; reg_widx = 4'd0; reg_wdata = 32'h10;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; reg_we = 1'b0;
        if (mode == 1) begin
            reg_we = 1'b1; reg_waddr = 3'd0; reg_widx = 4'd0; reg_wdata = 32'h55;
        end
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({name, "_busy"}, 32'(busy), 32'd1);
            seen = done;
        end
        reg_we = 1'b0;
        check({name, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rd(1, 0, 32'd0);

        for (int k = 0; k < 16; k++) hw(1, k, 32'(k));
        for (int k = 0; k < 16; k++) hw(2, k, 32'd100);
        run_cmd(ALU_ADD, 3, 1, 2, 16, 5, 0, "add16");
        for (int k = 0; k < 16; k++) rd(3, k, 32'(k) + 32'd100);
        drain();

        for (int k = 0; k < 16; k++) hw(3, k, 32'hDEAD);
        run_cmd(ALU_SUB, 3, 1, 2, 6, 3, 0, "sub6");
        for (int k = 0; k < 16; k++) rd(3, k, (k < 6) ? (32'(k) - 32'd100) : 32'hDEAD);
        drain();

        hw(1, 0, 32'h8000_0000);
        hw(2, 0, 32'd4);
        run_cmd(ALU_SRA, 3, 1, 2, 1, 2, 0, "sra1");
        run_cmd(ALU_SRL, 4, 1, 2, 1, 2, 0, "srl1");
        rd(3, 0, 32'hF800_0000);
        rd(4, 0, 32'h0800_0000);
        rd(3, 1, 32'd1 - 32'd100);
        drain();

        run_cmd(ALU_ADD, 5, 1, 2, 0, 1, 0, "vl0");
        rd(5, 0, 32'd0);
        run_cmd(ALU_ADD, 6, 2, 2, 20, 5, 0, "vl20");
        rd(6, 0, 32'd8);
        rd(6, 15, 32'd200);
        run_cmd(4'hF, 3, 1, 2, 4, 2, 0, "badop");
        rd(3, 0, 32'hF800_0000);
        rd(3, 3, 32'd3 - 32'd100);
        drain();

        hw(1, 0, 32'd0);
        for (int k = 0; k < 16; k++) hw(2, k, 32'd1);
        run_cmd(ALU_ADD, 1, 1, 2, 16, 5, 0, "alias");
        for (int k = 0; k < 16; k += 5) rd(1, k, 32'(k) + 32'd1);
        drain();

        run_cmd(ALU_ADD, 7, 2, 2, 8, 3, 1, "hw_in_exec");
        rd(0, 0, 32'd0);
        rd(7, 7, 32'd2);

        // Same-edge host write and read of v0[1]: old value first, new value next.
        step();
        reg_we = 1'b1; reg_waddr = 3'd0; reg_widx = 4'd1; reg_wdata = 32'h1234;
        rd_req = 1'b1; reg_raddr = 3'd0; reg_ridx = 4'd1;
        exp_q.push_back(32'd0); name_q.push_back("read_old");
        rd(0, 1, 32'h1234);
        drain();

        run_cmd(ALU_ADD, 7, 2, 2, 1, 2, 2, "hw_at_accept");
        rd(7, 0, 32'h20);
        rd(7, 1, 32'd2);
        drain();

        // Reset during beat 2 of a 16-element command.
        step();
        cmd_valid = 1'b1; cmd_op = ALU_ADD; cmd_vd = 3'd3; cmd_vs1 = 3'd1;
        cmd_vs2 = 3'd2; cmd_vl = 5'd16;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        begin
            int dcount = 0;
            if (done) dcount++;
            repeat (4) begin
                @(negedge clk);
                if (done) dcount++;
            end
            check("abort_no_done", 32'(dcount), 32'd0);
        end
        rd(1, 1, 32'd0);
        rd(2, 0, 32'd0);
        rd(3, 0, 32'd0);
        rd(6, 15, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
